// File: rtl/palu_param.sv
// palu_param: three-stage ALU pipeline (operand read, execute, write-back) with a
// 2**AW x WIDTH register file, full forwarding, registered flags and a debug read port.
// Optional liveness monitor, enabled by defining PALU_MONITOR_EN; when undefined the
// monitor is absent and o_fair is tied low. i_nd is the monitor's nondeterministic
// choice input and is ignored when the monitor is compiled out.
module palu_param #(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      AW        = 3,
   parameter int unsigned      WATCH_REG = 0,
   parameter logic [WIDTH-1:0] WATCH_VAL = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_stall,
   input  logic [2:0]       i_opcode,
   input  logic [AW-1:0]    i_src1,
   input  logic [AW-1:0]    i_src2,
   input  logic [AW-1:0]    i_dest,
   input  logic [WIDTH-1:0] i_imm,
   input  logic [AW-1:0]    i_dbg_addr,
   input  logic             i_nd,
   output logic [WIDTH-1:0] o_alu_out,
   output logic             o_zero_flag,
   output logic             o_carry_flag,
   output logic             o_wb_valid,
   output logic [WIDTH-1:0] o_dbg_data,
   output logic             o_fair
);

   localparam int unsigned   Depth    = 2 ** AW;
   localparam logic [AW-1:0] WatchIdx = AW'(WATCH_REG);

   typedef enum logic [2:0] {
      OpZero = 3'd0,
      OpLdi  = 3'd1,
      OpAdd  = 3'd2,
      OpSub  = 3'd3,
      OpNand = 3'd4,
      OpSrl  = 3'd5,
      OpCpa  = 3'd6,
      OpNot  = 3'd7
   } op_e;

   // Architectural and pipeline state
   logic [WIDTH-1:0] r_reg_file [Depth];
   logic [WIDTH-1:0] r_op1;
   logic [WIDTH-1:0] r_op2;
   logic [WIDTH-1:0] r_imm_ex;
   op_e              r_opcode_ex;
   logic [AW-1:0]    r_dest_ex;
   logic [AW-1:0]    r_dest_wb;
   logic [WIDTH-1:0] r_alu_out;
   logic             r_zero;
   logic             r_carry;
   logic             r_bubble_ex;
   logic             r_bubble_wb;
   logic             r_wb_valid;

   // Combinational helpers
   logic             w_wr_en;
   logic             w_ex_en;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_carry;
   logic             w_alu_zero;
   logic [WIDTH-1:0] w_alu_out_post;
   logic [AW-1:0]    w_dest_wb_post;
   logic [WIDTH-1:0] w_rf1;
   logic [WIDTH-1:0] w_rf2;
   logic [WIDTH-1:0] w_op1_next;
   logic [WIDTH-1:0] w_op2_next;
   logic [WIDTH-1:0] w_watch_now;
   logic             w_watch_hit;
   logic             w_trigger;

   assign w_wr_en = ~r_bubble_wb;
   assign w_ex_en = ~r_bubble_ex;
   assign w_sum   = {1'b0, r_op1} + {1'b0, r_op2};

   // ALU: result and carry/borrow for the instruction currently in EX
   always_comb begin
      w_alu_res   = '0;
      w_alu_carry = 1'b0;
      case (r_opcode_ex)
         OpZero: w_alu_res = '0;
         OpLdi:  w_alu_res = r_imm_ex;
         OpAdd: begin
            w_alu_res   = w_sum[WIDTH-1:0];
            w_alu_carry = w_sum[WIDTH];
         end
         OpSub: begin
            w_alu_res   = r_op1 - r_op2;
            w_alu_carry = (r_op1 < r_op2);
         end
         OpNand: w_alu_res = ~(r_op1 & r_op2);
         OpSrl:  w_alu_res = r_op1 >> 1;
         OpCpa:  w_alu_res = r_op1;
         OpNot:  w_alu_res = ~r_op1;
         default: begin
            w_alu_res   = '0;
            w_alu_carry = 1'b0;
         end
      endcase
   end

   assign w_alu_zero = (w_alu_res == '0);

   // Values of aluOut/destWb as they will be after this edge's execute step
   assign w_alu_out_post = w_ex_en ? w_alu_res : r_alu_out;
   assign w_dest_wb_post = w_ex_en ? r_dest_ex : r_dest_wb;

   // Register file as seen after this edge's write-back (write-through)
   assign w_rf1 = (w_wr_en && (i_src1 == r_dest_wb)) ? r_alu_out : r_reg_file[i_src1];
   assign w_rf2 = (w_wr_en && (i_src2 == r_dest_wb)) ? r_alu_out : r_reg_file[i_src2];

   // Forwarding compares against destWb unconditionally; after reset destWb/aluOut are 0
   // and match r0, and afterwards aluOut always equals regFile[destWb] once written.
   assign w_op1_next = (i_src1 == w_dest_wb_post) ? w_alu_out_post : w_rf1;
   assign w_op2_next = (i_src2 == w_dest_wb_post) ? w_alu_out_post : w_rf2;

   // Monitor observation: watched register after write-back, and LDI trigger in EX
   assign w_watch_now = (w_wr_en && (r_dest_wb == WatchIdx)) ? r_alu_out
                                                              : r_reg_file[WatchIdx];
   assign w_watch_hit = (w_watch_now == WATCH_VAL);
   assign w_trigger   = w_ex_en && (r_opcode_ex == OpLdi) && (r_dest_ex == WatchIdx) &&
                        (r_imm_ex == WATCH_VAL);

   // Write-back stage: commit the previous EX result unless it was a bubble
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int i = 0; i < Depth; i++) begin
            r_reg_file[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_reg_file[r_dest_wb] <= r_alu_out;
      end
   end

   // Execute stage: result, flags and destination are only updated by real instructions
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_alu_out <= '0;
         r_zero    <= 1'b1;
         r_carry   <= 1'b0;
         r_dest_wb <= '0;
      end else if (w_ex_en) begin
         r_alu_out <= w_alu_res;
         r_zero    <= w_alu_zero;
         r_carry   <= w_alu_carry;
         r_dest_wb <= r_dest_ex;
      end
   end

   // Operand read stage: capture a new instruction unless stalled (stall holds operands)
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_op1       <= '0;
         r_op2       <= '0;
         r_imm_ex    <= '0;
         r_opcode_ex <= OpZero;
         r_dest_ex   <= '0;
      end else if (!i_stall) begin
         r_op1       <= w_op1_next;
         r_op2       <= w_op2_next;
         r_imm_ex    <= i_imm;
         r_opcode_ex <= op_e'(i_opcode);
         r_dest_ex   <= i_dest;
      end
   end

   // Bubble tracking: a stall inserts a bubble that walks EX then WB
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_bubble_ex <= 1'b1;
         r_bubble_wb <= 1'b1;
         r_wb_valid  <= 1'b0;
      end else begin
         r_bubble_wb <= r_bubble_ex;
         r_bubble_ex <= i_stall;
         r_wb_valid  <= ~r_bubble_ex;
      end
   end

   assign o_alu_out    = r_alu_out;
   assign o_zero_flag  = r_zero;
   assign o_carry_flag = r_carry;
   assign o_wb_valid   = r_wb_valid;
   assign o_dbg_data   = r_reg_file[i_dbg_addr];

`ifdef PALU_MONITOR_EN
   // Buchi monitor for G(trigger -> F regFile[WATCH_REG] == WATCH_VAL)
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StDone = 2'd2
   } mon_e;

   mon_e r_mon_state;
   mon_e w_mon_next;
   logic w_fair;

   // Monitor state register
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_mon_state <= StIdle;
      end else begin
         r_mon_state <= w_mon_next;
      end
   end

   // Monitor next state; i_nd resolves the nondeterministic choice on trigger
   always_comb begin
      w_mon_next = r_mon_state;
      case (r_mon_state)
         StIdle:  w_mon_next = (w_trigger && i_nd) ? StWait : StIdle;
         StWait:  w_mon_next = w_watch_hit ? StDone : StWait;
         StDone:  w_mon_next = StDone;
         default: w_mon_next = StIdle;
      endcase
   end

   // Monitor output: fairness holds while waiting for the watched value
   always_comb begin
      w_fair = (r_mon_state == StWait);
   end

   assign o_fair = w_fair;
`else
   logic unused_mon;
   assign unused_mon = ^{i_nd, w_trigger, w_watch_hit};
   assign o_fair     = 1'b0;
`endif

endmodule
